// File: rtl/loctag_pkg.sv
// Shared types and constants for the loctag backscatter transmitter.
package loctag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BACKOFF,
        ST_PREAMBLE,
        ST_DATA,
        ST_GUARD
    } state_t;

    localparam logic [1:0] MODE_OOK = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_RR  = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/loctag_lfsr16.sv
// 16-bit Galois LFSR used as the slotted-ALOHA random source.
module loctag_lfsr16 #(
    parameter logic [15:0] SEED = 16'hF1B7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);
    import loctag_pkg::*;

    // An all-zero state would lock up the register.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= SEED_EFF;
        end else if (step) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/loctag_bs_tx.sv
// Backscatter frame transmitter: trigger sync, slotted backoff, Manchester
// preamble + tag ID onto the reflector switches in OOK, subcarrier or round-robin form.
module loctag_bs_tx #(
    parameter int          N_CTRL       = 2,
    parameter int          ID_BYTES     = 16,
    parameter int          PRE_BITS     = 8,
    parameter int          BIT_CYCLES   = 50,
    parameter int          SUB_DIV      = 5,
    parameter int          SLOT_CYCLES  = 8192,
    parameter int          GUARD_CYCLES = 64,
    parameter logic [15:0] MAC_SEED     = 16'hF1B7,
    parameter int          MAC_Q        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trig,
    input  logic [8*ID_BYTES-1:0] tag_id,
    input  logic                  force_fs,
    input  logic [1:0]            mode,
    output logic [N_CTRL-1:0]     ctrl,
    output logic                  busy,
    output logic                  done,
    output logic [MAC_Q-1:0]      slot,
    output logic                  led
);
    import loctag_pkg::*;

    localparam int FRAME_BITS = PRE_BITS + 8 * ID_BYTES;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CYC_W      = cnt_w(BIT_CYCLES);
    localparam int BIT_W      = cnt_w(FRAME_BITS + 1);
    localparam int GRD_W      = cnt_w(GUARD_CYCLES);
    localparam int SUB_W      = cnt_w(SUB_DIV);
    localparam int RR_W       = cnt_w(N_CTRL);
    localparam int BO_W       = cnt_w(((1 << MAC_Q) - 1) * SLOT_CYCLES + 1);
    localparam int LED_W      = 21;

    function automatic logic [PRE_BITS-1:0] pre_pattern();
        logic [PRE_BITS-1:0] p;
        for (int i = 0; i < PRE_BITS; i++) begin
            p[i] = ((PRE_BITS - 1 - i) % 2) == 0;
        end
        return p;
    endfunction

    localparam logic [PRE_BITS-1:0] PRE_PAT = pre_pattern();

    state_t                state, state_n;
    logic                  sync1, sync2, sync3;
    logic [15:0]           lfsr;
    logic [MAC_Q-1:0]      slot_sel;
    logic [1:0]            mode_q;
    logic [FRAME_BITS-1:0] frame_sr;
    logic [BO_W-1:0]       bo_cnt;
    logic [CYC_W-1:0]      cyc_cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [RR_W-1:0]       rr_idx;
    logic [SUB_W-1:0]      sub_cnt;
    logic                  sub_lvl;
    logic [GRD_W-1:0]      guard_cnt;
    logic [LED_W-1:0]      led_cnt;
    logic                  accept, bit_end, in_frame, level;
    logic [N_CTRL-1:0]     ctrl_n;
    logic                  done_n;

    loctag_lfsr16 #(.SEED(MAC_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (1'b1),
        .value (lfsr)
    );

    assign slot_sel = MAC_Q'(lfsr % 16'(1 << MAC_Q));
    assign accept   = (state == ST_IDLE) && sync2 && !sync3 && (mode != MODE_OFF);
    assign bit_end  = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));
    assign in_frame = (state == ST_PREAMBLE) || (state == ST_DATA);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (accept) state_n = ST_BACKOFF;
            ST_BACKOFF:  if (bo_cnt == '0) state_n = ST_PREAMBLE;
            ST_PREAMBLE: if (bit_end && bit_idx == BIT_W'(PRE_BITS - 1)) state_n = ST_DATA;
            ST_DATA:     if (bit_end && bit_idx == BIT_W'(FRAME_BITS - 1)) state_n = ST_GUARD;
            ST_GUARD:    if (guard_cnt == GRD_W'(GUARD_CYCLES - 1)) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // The frame shift register MSB is the current bit; the first half carries it, the second its inverse.
    always_comb begin
        level  = (cyc_cnt < CYC_W'(HALF)) ? frame_sr[FRAME_BITS-1] : ~frame_sr[FRAME_BITS-1];
        ctrl_n = '0;
        done_n = (state == ST_GUARD) && (guard_cnt == GRD_W'(GUARD_CYCLES - 1));
        if (in_frame) begin
            case (mode_q)
                MODE_OOK: ctrl_n[0]      = level;
                MODE_SUB: ctrl_n[0]      = level & sub_lvl;
                MODE_RR:  ctrl_n[rr_idx] = level;
                default:  ctrl_n         = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            mode_q    <= MODE_OOK;
            frame_sr  <= '0;
            bo_cnt    <= '0;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            rr_idx    <= '0;
            sub_cnt   <= '0;
            sub_lvl   <= 1'b1;
            guard_cnt <= '0;
            led_cnt   <= '0;
            slot      <= '0;
            ctrl      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            led       <= 1'b0;
        end else begin
            sync1 <= trig;
            sync2 <= sync1;
            sync3 <= sync2;

            if (accept) begin
                mode_q   <= mode;
                frame_sr <= {PRE_PAT, tag_id};
                slot     <= force_fs ? '0 : slot_sel;
                bo_cnt   <= force_fs ? '0 : BO_W'(slot_sel) * BO_W'(SLOT_CYCLES);
            end else if (state == ST_BACKOFF && bo_cnt != '0) begin
                bo_cnt <= bo_cnt - 1'b1;
            end

            // The subcarrier phase runs continuously across the frame, starting high.
            if (in_frame) begin
                cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
                if (bit_end) begin
                    bit_idx  <= bit_idx + 1'b1;
                    frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
                    rr_idx   <= (rr_idx == RR_W'(N_CTRL - 1)) ? '0 : rr_idx + 1'b1;
                end
                if (sub_cnt == SUB_W'(SUB_DIV - 1)) begin
                    sub_cnt <= '0;
                    sub_lvl <= ~sub_lvl;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end else begin
                cyc_cnt <= '0;
                bit_idx <= '0;
                rr_idx  <= '0;
                sub_cnt <= '0;
                sub_lvl <= 1'b1;
            end

            guard_cnt <= (state == ST_GUARD) ? guard_cnt + 1'b1 : '0;

            if (done_n) begin
                led_cnt <= LED_W'(1) << 20;
            end else if (led_cnt != '0) begin
                led_cnt <= led_cnt - 1'b1;
            end

            ctrl <= ctrl_n;
            done <= done_n;
            led  <= accept || (state != ST_IDLE) || (led_cnt != '0);
            if (accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_loctag_bs_tx.sv
// Directed bench for loctag_bs_tx with small frame parameters (16-bit frames, 4-cycle bits).
module tb_loctag_bs_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] tag_id = 8'h00;
    logic       force_fs = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] ctrl;
    logic       busy, done, led;
    logic [1:0] slot;

    int checks = 0;
    int failures = 0;

    loctag_bs_tx #(
        .N_CTRL(2), .ID_BYTES(1), .PRE_BITS(8), .BIT_CYCLES(4), .SUB_DIV(5),
        .SLOT_CYCLES(128), .GUARD_CYCLES(8), .MAC_SEED(16'hF1B7), .MAC_Q(2)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig), .tag_id(tag_id), .force_fs(force_fs),
        .mode(mode), .ctrl(ctrl), .busy(busy), .done(done), .slot(slot), .led(led)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, taps 16'hB400, reloaded whenever reset is low.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (!reset) m_lfsr <= 16'hF1B7;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected ctrl for frame cycle k (0 = first half of the first preamble bit).
    function automatic logic [1:0] exp_ctrl(input logic [1:0] m, input logic [7:0] tag, input int k);
        int   b;
        int   h;
        logic v;
        logic lvl;
        b   = k / 4;
        h   = (k % 4) / 2;
        v   = (b < 8) ? ((b % 2) == 0) : tag[7 - (b - 8)];
        lvl = (h == 0) ? v : ~v;
        case (m)
            2'b00:   return {1'b0, lvl};
            2'b01:   return {1'b0, lvl & (((k / 5) % 2) == 0)};
            2'b10:   return lvl ? (((b % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    typedef struct {
        logic [1:0] mode;
        logic       force_fs;
        logic [7:0] tag;
        logic       extra;
        int         exp_slot;
        int         exp_done;
    } vec_t;

    // exp_slot < 0: slot comes from the reference LFSR; exp_done is relative to T0 plus slot*128.
    vec_t vecs[6];

    // n counts edges from T0 (n=1 is T0); accept is at n=3, first ctrl at n=5+off, done at n=76+off.
    task automatic run_frame(input vec_t v, input int idx);
        int n, last, slot_exp, off;
        int ctrl_err, busy_err, both, done_cnt, done_at, bad_n;
        logic [1:0] ec;
        logic       eb;
        n = 0; last = 100; slot_exp = 0; off = 0;
        ctrl_err = 0; busy_err = 0; both = 0; done_cnt = 0; done_at = -1; bad_n = -1;
        @(negedge clk);
        mode = v.mode; force_fs = v.force_fs; tag_id = v.tag; trig = 1'b1;
        while (n < last) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) begin
                slot_exp = (v.exp_slot >= 0) ? v.exp_slot : int'(m_lfsr[1:0]);
                off      = slot_exp * 128;
                last     = off + v.exp_done + 12;
            end
            if (n == 3) begin
                mode = ~v.mode; tag_id = ~v.tag; force_fs = ~v.force_fs; trig = 1'b0;
            end
            if (v.extra) begin
                if (n == 20 || n == off + 35) trig = 1'b1;
                if (n == 23 || n == off + 38) trig = 1'b0;
            end
            ec = (n >= off + 5 && n <= off + 68) ? exp_ctrl(v.mode, v.tag, n - off - 5) : 2'b00;
            eb = (n >= 3) && (n <= off + v.exp_done);
            if (ctrl !== ec) begin
                ctrl_err++;
                if (bad_n < 0) bad_n = n;
            end
            if (busy !== eb) busy_err++;
            if (ctrl === 2'b11) both++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
        end
        check($sformatf("v%0d_ctrl_wave_errs(first_n=%0d)", idx, bad_n), ctrl_err, 0);
        check($sformatf("v%0d_busy_wave_errs", idx), busy_err, 0);
        check($sformatf("v%0d_ctrl_both_high", idx), both, 0);
        check($sformatf("v%0d_done_count", idx), done_cnt, 1);
        check($sformatf("v%0d_done_cycle", idx), done_at, off + v.exp_done);
        check($sformatf("v%0d_slot", idx), slot, slot_exp);
        check($sformatf("v%0d_led_stretch", idx), led, 1);
        mode = 2'b00; force_fs = 1'b0;
    endtask

    initial begin
        int busy_hi, ctrl_hi;
        vecs[0] = '{2'b00, 1'b1, 8'hC5, 1'b1,  0, 76};
        vecs[1] = '{2'b10, 1'b1, 8'h3A, 1'b1,  0, 76};
        vecs[2] = '{2'b01, 1'b1, 8'hFF, 1'b0,  0, 76};
        vecs[3] = '{2'b00, 1'b0, 8'h96, 1'b1, -1, 76};
        vecs[4] = '{2'b10, 1'b0, 8'h5B, 1'b1, -1, 76};
        vecs[5] = '{2'b01, 1'b0, 8'hA7, 1'b0, -1, 76};

        // Power-on reset.
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_ctrl", ctrl, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_slot", slot, 0);
        check("rst_led", led, 0);
        @(negedge clk); reset = 1'b1;
        repeat (5) @(posedge clk);

        // Reset held 3 cycles mid-DATA.
        @(negedge clk);
        mode = 2'b00; force_fs = 1'b1; tag_id = 8'hC5; trig = 1'b1;
        repeat (3) @(posedge clk);
        #1 trig = 1'b0;
        repeat (42) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ctrl", ctrl, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_slot", slot, 0);
        check("midrst_led", led, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        repeat (6) @(posedge clk);

        // Mode 11: trigger ignored.
        busy_hi = 0; ctrl_hi = 0;
        @(negedge clk); mode = 2'b11; force_fs = 1'b1; trig = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) busy_hi++;
            if (ctrl !== 2'b00) ctrl_hi++;
        end
        check("mode11_busy_cycles", busy_hi, 0);
        check("mode11_ctrl_cycles", ctrl_hi, 0);
        @(negedge clk); trig = 1'b0; mode = 2'b00;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], i);
            repeat (5) @(posedge clk);
        end

        #1;
        check("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
